// File: rtl/pipe_hold_ctrl_if.sv
// Hold/redirect signal bundle between the pipeline control block and its
// clients: the redirect and stall requests going in, the hold codes and PC redirect coming out.
interface pipe_hold_ctrl_if;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        int_assert_i;
  logic [31:0] int_addr_i;
  logic        hold_ex_i;
  logic        hold_bus_i;
  logic [2:0]  hold_flag_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic [7:0]  stall_cnt_o;
  logic        bus_timeout_o;

  modport master (
    output jump_flag_i, jump_addr_i, int_assert_i, int_addr_i, hold_ex_i, hold_bus_i,
    input  hold_flag_o, jump_flag_o, jump_addr_o, stall_cnt_o, bus_timeout_o
  );

  modport slave (
    input  jump_flag_i, jump_addr_i, int_assert_i, int_addr_i, hold_ex_i, hold_bus_i,
    output hold_flag_o, jump_flag_o, jump_addr_o, stall_cnt_o, bus_timeout_o
  );
endinterface

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/redirect controller: zero-latency redirect and hold decode,
// post-redirect bubble insertion, and stall-episode counting with bus timeout.
module pipe_hold_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int BUS_TIMEOUT  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  pipe_hold_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, FLUSH, EX_WAIT, BUS_WAIT} state_t;

  state_t      state, state_nxt, kind;
  logic [2:0]  flush_cnt, flush_nxt;
  logic [7:0]  stall_cnt, stall_nxt, stall_view;
  logic        to_done, to_done_nxt, to_pulse, in_episode;
  logic [2:0]  hold;
  logic        jump;
  logic [31:0] target;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // kind is what the current cycle is doing; state is what the previous cycle
  // decided, so kind == state means the same stall episode continues.
  always_comb begin
    kind      = RUN;
    state_nxt = RUN;
    flush_nxt = 3'd0;
    hold      = 3'd0;
    jump      = 1'b0;
    target    = 32'd0;
    if (bus.int_assert_i || bus.jump_flag_i) begin
      jump      = 1'b1;
      target    = bus.int_assert_i ? bus.int_addr_i : bus.jump_addr_i;
      hold      = 3'd3;
      kind      = FLUSH;
      state_nxt = FLUSH;
      flush_nxt = 3'(FLUSH_CYCLES);
    end else if (state == FLUSH) begin
      hold      = 3'd2;
      kind      = FLUSH;
      flush_nxt = flush_cnt - 3'd1;
      if (flush_nxt != 3'd0)   state_nxt = FLUSH;
      else if (bus.hold_ex_i)  state_nxt = EX_WAIT;
      else if (bus.hold_bus_i) state_nxt = BUS_WAIT;
      else                     state_nxt = RUN;
    end else if (bus.hold_ex_i) begin
      hold      = 3'd3;
      kind      = EX_WAIT;
      state_nxt = EX_WAIT;
    end else if (bus.hold_bus_i) begin
      hold      = 3'd1;
      kind      = BUS_WAIT;
      state_nxt = BUS_WAIT;
    end

    in_episode = (kind == state) && ((kind == EX_WAIT) || (kind == BUS_WAIT));
    stall_view = in_episode ? stall_cnt : 8'd0;
    if ((kind == EX_WAIT) || (kind == BUS_WAIT))
      stall_nxt = in_episode ? sat_inc(stall_cnt) : 8'd1;
    else
      stall_nxt = 8'd0;

    // to_done blocks a second pulse when the count saturates at BUS_TIMEOUT=255
    to_pulse    = in_episode && (kind == BUS_WAIT) &&
                  (stall_cnt == 8'(BUS_TIMEOUT)) && !to_done;
    to_done_nxt = (in_episode && (kind == BUS_WAIT)) ? (to_done | to_pulse) : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      flush_cnt <= 3'd0;
      stall_cnt <= 8'd0;
      to_done   <= 1'b0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_nxt;
      stall_cnt <= stall_nxt;
      to_done   <= to_done_nxt;
    end
  end

  // Outputs are combinational on the inputs, so reset must mask them directly.
  assign bus.hold_flag_o   = rst_n ? hold       : 3'd0;
  assign bus.jump_flag_o   = rst_n ? jump       : 1'b0;
  assign bus.jump_addr_o   = rst_n ? target     : 32'd0;
  assign bus.stall_cnt_o   = rst_n ? stall_view : 8'd0;
  assign bus.bus_timeout_o = rst_n ? to_pulse   : 1'b0;

endmodule

// File: doc/pipe_hold_ctrl.md
PIPE_HOLD_CTRL -- requirements
Module: pipe_hold_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 1, range 1-7: bubble cycles inserted after a redirect cycle.
REQ-002 Parameter BUS_TIMEOUT, default 16, range 2-255: bus-stall cycle count that raises bus_timeout_o.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 jump_flag_i  input  1  execute-stage branch/jump taken.
REQ-006 jump_addr_i  input  32  execute-stage redirect target.
REQ-007 int_assert_i  input  1  interrupt controller requests a redirect.
REQ-008 int_addr_i  input  32  interrupt redirect target.
REQ-009 hold_ex_i  input  1  execute multi-cycle operation busy (div/mul).
REQ-010 hold_bus_i  input  1  bus arbiter withholds the fetch port.
REQ-011 hold_flag_o  output  3  pipeline hold code: 0 none, 1 hold PC, 2 hold PC+IF/ID (bubble), 3 hold PC+IF/ID+ID/EX (full bubble); the decode-to-execute register inserts a NOP when the code is >=2.
REQ-012 jump_flag_o  output  1  PC redirect strobe.
REQ-013 jump_addr_o  output  32  PC redirect target.
REQ-014 stall_cnt_o  output  8  consecutive cycles of the current EX_WAIT or BUS_WAIT episode, saturating at 255.
REQ-015 bus_timeout_o  output  1  one-cycle pulse on reaching BUS_TIMEOUT.

Function
REQ-016 FSM states SHALL be RUN, FLUSH, EX_WAIT and BUS_WAIT, held in registers.
REQ-017 Input priority SHALL be int_assert_i > jump_flag_i > hold_ex_i > hold_bus_i, evaluated every cycle in every state.
REQ-018 Redirect cycle (int_assert_i or jump_flag_i high): jump_flag_o=1, jump_addr_o=int_addr_i if int_assert_i else jump_addr_i, hold_flag_o=3, all combinational in the same cycle (zero latency).
REQ-019 After a redirect: next state FLUSH, flush counter loaded with FLUSH_CYCLES.
REQ-020 In FLUSH with no new redirect: hold_flag_o=2, jump_flag_o=0; counter decrements; on reaching 0, next state is RUN, or EX_WAIT/BUS_WAIT if the respective hold input is high.
REQ-021 A redirect arriving in FLUSH SHALL be accepted per REQ-018 and SHALL reload the counter to FLUSH_CYCLES.
REQ-022 hold_ex_i high with no redirect: hold_flag_o=3 in the same cycle; state EX_WAIT; remain until hold_ex_i falls.
REQ-023 hold_bus_i high with no redirect and no hold_ex_i: hold_flag_o=1; state BUS_WAIT; remain until hold_bus_i falls.
REQ-024 stall_cnt_o SHALL clear on entry to EX_WAIT or BUS_WAIT, including an EX_WAIT<->BUS_WAIT transfer, increment by 1 per cycle in that state, saturate at 255, and clear on return to RUN or FLUSH.
REQ-025 bus_timeout_o SHALL pulse for exactly one cycle when stall_cnt_o reaches BUS_TIMEOUT in BUS_WAIT; there is no re-pulse within the same episode; hold continues.
REQ-026 In RUN with no requests: hold_flag_o=0, jump_flag_o=0, jump_addr_o=0.
REQ-027 When jump_flag_o=0, jump_addr_o SHALL be 0.
REQ-028 The release cycle SHALL be combinational: the cycle in which the hold input falls already shows hold_flag_o=0, unless another request is active.

Reset
REQ-029 While rst_n=0: state RUN, flush counter 0, stall_cnt_o=0, bus_timeout_o=0, hold_flag_o=0, jump_flag_o=0, jump_addr_o=0, regardless of input activity.
REQ-030 Reset asserted mid-FLUSH or mid-stall SHALL abort the operation immediately, with no residual bubble after release.
REQ-031 First edge after rst_n rises SHALL evaluate inputs as from RUN.

Verification
REQ-032 jump_flag_i=1, jump_addr_i=0x0000_0100 for 1 cycle, FLUSH_CYCLES=1 -> cycle0: hold=3, jump_flag_o=1, addr=0x100; cycle1: hold=2; cycle2: hold=0.
REQ-033 int_assert_i and jump_flag_i same cycle, int_addr_i=0x8, jump_addr_i=0x200 -> jump_addr_o=0x8, hold=3.
REQ-034 hold_ex_i high 5 cycles -> hold=3 for those 5 cycles, stall_cnt_o 0..4, hold=0 on the release cycle.
REQ-035 hold_bus_i high 20 cycles, BUS_TIMEOUT=16 -> hold=1 throughout, single bus_timeout_o pulse when stall_cnt_o=16.
REQ-036 Second jump during FLUSH with FLUSH_CYCLES=3 -> new address output, hold=2 lasts 3 cycles after the second jump.
REQ-037 rst_n low during EX_WAIT with stall_cnt_o=3 -> all outputs 0 asynchronously; RUN after release.
